// File: rtl/piezo_arbiter.sv
// Shares one piezo tone generator among three prioritised sound requesters.
// Requests are buffered one-deep, timed in 1 ms ticks and separated by a silent gap.
module piezo_arbiter #(
  parameter int GAP_MS  = 20,
  parameter bit PREEMPT = 1'b1,
  parameter int DUR_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_clear,
  input  logic [2:0]       i_req,
  input  logic [31:0]      i_limit0,
  input  logic [31:0]      i_limit1,
  input  logic [31:0]      i_limit2,
  input  logic [DUR_W-1:0] i_dur0,
  input  logic [DUR_W-1:0] i_dur1,
  input  logic [DUR_W-1:0] i_dur2,
  output logic             o_play_en,
  output logic [31:0]      o_cnt_limit,
  output logic [1:0]       o_owner,
  output logic             o_busy,
  output logic [2:0]       o_drop
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PLAY    = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;
  localparam logic [1:0] OWNER_NONE = 2'd3;

  // One counter serves both tone length and gap length, so size it for the larger.
  localparam int GAP_W = (GAP_MS > 1) ? $clog2(GAP_MS + 1) : 1;
  localparam int CNT_W = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_MS);

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [31:0]      lim_q, lim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       drop_q, drop_d;
  logic [2:0]       slot_vld_q, slot_vld_d;
  logic [31:0]      slot_lim_q [3];
  logic [31:0]      slot_lim_d [3];
  logic [DUR_W-1:0] slot_dur_q [3];
  logic [DUR_W-1:0] slot_dur_d [3];

  logic [31:0]      req_lim [3];
  logic [DUR_W-1:0] req_dur [3];

  logic       any_vld;
  logic [1:0] win;
  logic       tone_end;
  logic       gap_end;
  logic       preempt;
  logic       grant;

  assign req_lim[0] = i_limit0;
  assign req_lim[1] = i_limit1;
  assign req_lim[2] = i_limit2;
  assign req_dur[0] = i_dur0;
  assign req_dur[1] = i_dur1;
  assign req_dur[2] = i_dur2;

  // Arbitration only looks at registered slots, so a fresh strobe is seen one edge later.
  always_comb begin
    any_vld = |slot_vld_q;
    if (slot_vld_q[2])      win = 2'd2;
    else if (slot_vld_q[1]) win = 2'd1;
    else                    win = 2'd0;
    tone_end = (state_q == ST_PLAY) && i_tick && (cnt_q == CNT_ONE);
    gap_end  = (state_q == ST_GAP)  && i_tick && (cnt_q == CNT_ONE);
    // A tone finishing on this very tick completes normally rather than being cut.
    preempt  = PREEMPT && (state_q == ST_PLAY) && !tone_end && any_vld && (win > owner_q);
    grant    = any_vld && ((state_q == ST_IDLE) || gap_end || preempt ||
                           (tone_end && (GAP_MS == 0)));
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lim_d      = lim_q;
    cnt_d      = cnt_q;
    drop_d     = '0;
    slot_vld_d = slot_vld_q;
    for (int i = 0; i < 3; i++) begin
      slot_lim_d[i] = slot_lim_q[i];
      slot_dur_d[i] = slot_dur_q[i];
    end

    case (state_q)
      ST_PLAY: begin
        if (tone_end) begin
          state_d = (GAP_MS == 0) ? ST_IDLE : ST_GAP;
          cnt_d   = GAP_LOAD;
          owner_d = OWNER_NONE;
          lim_d   = '0;
        end else if (i_tick) begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (gap_end)     state_d = ST_IDLE;
        else if (i_tick) cnt_d   = cnt_q - CNT_ONE;
      end
      default: ;
    endcase

    if (preempt) drop_d = drop_d | (3'b001 << owner_q);

    // The grant reloads the counter, which also swallows any tick in this cycle.
    if (grant) begin
      state_d         = ST_PLAY;
      owner_d         = win;
      lim_d           = slot_lim_q[win];
      cnt_d           = CNT_W'(slot_dur_q[win]);
      slot_vld_d[win] = 1'b0;
    end

    for (int i = 0; i < 3; i++) begin
      if (i_req[i]) begin
        if (req_dur[i] == '0) begin
          drop_d[i] = 1'b1;
        end else begin
          if (slot_vld_q[i] && !(grant && (win == 2'(i)))) drop_d[i] = 1'b1;
          slot_vld_d[i] = 1'b1;
          slot_lim_d[i] = req_lim[i];
          slot_dur_d[i] = req_dur[i];
        end
      end
    end

    if (i_clear) begin
      state_d    = ST_IDLE;
      owner_d    = OWNER_NONE;
      lim_d      = '0;
      cnt_d      = '0;
      drop_d     = '0;
      slot_vld_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_NONE;
      lim_q      <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      slot_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lim_q      <= lim_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      slot_vld_q <= slot_vld_d;
    end
  end

  // NOTE: slot payload is not reset; it is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      slot_lim_q[i] <= slot_lim_d[i];
      slot_dur_q[i] <= slot_dur_d[i];
    end
  end

  assign o_play_en   = (state_q == ST_PLAY);
  assign o_cnt_limit = lim_q;
  assign o_owner     = owner_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_piezo_arbiter.sv
// Scoreboard bench for piezo_arbiter: three instances (default, no preemption, no gap),
// expected tone segments and drop pulses queued by stimulus, checked by a negedge monitor.
module tb_piezo_arbiter;

  localparam int TP = 4;

  typedef struct {
    int     kind;
    int     owner;
    longint limit;
    int     ticks;
    int     gap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        clr      [3];
  logic [2:0]  req      [3];
  logic [31:0] lim      [3][3];
  logic [15:0] dur      [3][3];
  logic        play_en  [3];
  logic [31:0] cnt_lim  [3];
  logic [1:0]  owner    [3];
  logic        busy     [3];
  logic [2:0]  drop     [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t       seg_q  [3][$];
  logic [2:0] drop_q [3][$];

  bit          in_seg    [3];
  bit          busy_prev [3];
  logic [1:0]  cur_own   [3];
  logic [31:0] cur_lim   [3];
  int          seg_ticks [3];
  int          seg_gap   [3];
  int          seg_sil   [3];
  int          gap_ticks [3];
  int          silent    [3];

  always #5 clk = ~clk;

  piezo_arbiter #(.GAP_MS(20), .PREEMPT(1'b1), .DUR_W(16)) u_def (
    .clk(clk), .rst(rst), .i_tick(tick), .i_clear(clr[0]), .i_req(req[0]),
    .i_limit0(lim[0][0]), .i_limit1(lim[0][1]), .i_limit2(lim[0][2]),
    .i_dur0(dur[0][0]), .i_dur1(dur[0][1]), .i_dur2(dur[0][2]),
    .o_play_en(play_en[0]), .o_cnt_limit(cnt_lim[0]), .o_owner(owner[0]),
    .o_busy(busy[0]), .o_drop(drop[0]));

  piezo_arbiter #(.GAP_MS(20), .PREEMPT(1'b0), .DUR_W(16)) u_nopre (
    .clk(clk), .rst(rst), .i_tick(tick), .i_clear(clr[1]), .i_req(req[1]),
    .i_limit0(lim[1][0]), .i_limit1(lim[1][1]), .i_limit2(lim[1][2]),
    .i_dur0(dur[1][0]), .i_dur1(dur[1][1]), .i_dur2(dur[1][2]),
    .o_play_en(play_en[1]), .o_cnt_limit(cnt_lim[1]), .o_owner(owner[1]),
    .o_busy(busy[1]), .o_drop(drop[1]));

  piezo_arbiter #(.GAP_MS(0), .PREEMPT(1'b1), .DUR_W(16)) u_nogap (
    .clk(clk), .rst(rst), .i_tick(tick), .i_clear(clr[2]), .i_req(req[2]),
    .i_limit0(lim[2][0]), .i_limit1(lim[2][1]), .i_limit2(lim[2][2]),
    .i_dur0(dur[2][0]), .i_dur1(dur[2][1]), .i_dur2(dur[2][2]),
    .o_play_en(play_en[2]), .o_cnt_limit(cnt_lim[2]), .o_owner(owner[2]),
    .o_busy(busy[2]), .o_drop(drop[2]));

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic end_seg(int k);
    exp_t e;
    check($sformatf("u%0d_seg_expected", k), longint'(seg_q[k].size() > 0), 1);
    if (seg_q[k].size() > 0) begin
      e = seg_q[k].pop_front();
      check($sformatf("u%0d_seg_kind", k), 0, e.kind);
      check($sformatf("u%0d_seg_owner", k), longint'(cur_own[k]), e.owner);
      check($sformatf("u%0d_seg_limit", k), longint'(cur_lim[k]), e.limit);
      if (e.ticks >= 0) check($sformatf("u%0d_seg_ticks", k), seg_ticks[k], e.ticks);
      check($sformatf("u%0d_seg_gap_ticks", k), seg_gap[k], e.gap);
      check($sformatf("u%0d_seg_no_silent_cycle", k), longint'(seg_sil[k] == 0),
            longint'(e.gap == 0));
    end
  endtask

  task automatic idle_evt(int k);
    exp_t e;
    check($sformatf("u%0d_idle_expected", k), longint'(seg_q[k].size() > 0), 1);
    if (seg_q[k].size() > 0) begin
      e = seg_q[k].pop_front();
      check($sformatf("u%0d_idle_kind", k), 1, e.kind);
      if (e.gap >= 0) check($sformatf("u%0d_idle_gap_ticks", k), gap_ticks[k], e.gap);
    end
  endtask

  task automatic mon(int k);
    if (in_seg[k] && (!play_en[k] || owner[k] != cur_own[k] || cnt_lim[k] != cur_lim[k])) begin
      end_seg(k);
      in_seg[k] = 1'b0;
    end
    if (busy_prev[k] && !busy[k]) begin
      idle_evt(k);
      gap_ticks[k] = 0;
      silent[k]    = 0;
    end
    if (play_en[k] && !in_seg[k]) begin
      in_seg[k]    = 1'b1;
      cur_own[k]   = owner[k];
      cur_lim[k]   = cnt_lim[k];
      seg_ticks[k] = 0;
      seg_gap[k]   = gap_ticks[k];
      seg_sil[k]   = silent[k];
      gap_ticks[k] = 0;
      silent[k]    = 0;
    end
    if (play_en[k]) begin
      if (tick) seg_ticks[k]++;
    end else if (busy[k]) begin
      if (tick) gap_ticks[k]++;
      silent[k]++;
    end
    if (drop[k] != 3'b000) begin
      check($sformatf("u%0d_drop_expected", k), longint'(drop_q[k].size() > 0), 1);
      if (drop_q[k].size() > 0)
        check($sformatf("u%0d_drop_mask", k), longint'(drop[k]), longint'(drop_q[k].pop_front()));
    end
    busy_prev[k] = busy[k];
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
  end

  // ---------------- tick generator ----------------
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (cyc % TP == TP - 1);
      cyc++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(int k, int i, int l, int d);
    lim[k][i] = 32'(l);
    dur[k][i] = 16'(d);
    req[k][i] = 1'b1;
  endtask

  task automatic issue(int k);
    step();
    req[k] = 3'b000;
  endtask

  task automatic exp_seg(int k, int o, longint l, int t, int g);
    seg_q[k].push_back('{0, o, l, t, g});
  endtask

  task automatic exp_idle(int k, int g);
    seg_q[k].push_back('{1, 0, 0, 0, g});
  endtask

  task automatic exp_drop(int k, logic [2:0] m);
    drop_q[k].push_back(m);
  endtask

  task automatic wait_play(int k);
    int c = 0;
    while (!play_en[k] && c < 4000) begin step(); c++; end
    check($sformatf("u%0d_wait_play", k), longint'(play_en[k]), 1);
  endtask

  task automatic wait_silent(int k);
    int c = 0;
    while (play_en[k] && c < 4000) begin step(); c++; end
    check($sformatf("u%0d_wait_silent", k), longint'(play_en[k]), 0);
  endtask

  // Ends in the cycle carrying the n-th tick, counting the current cycle.
  task automatic wait_ticks(int n);
    int seen = 0;
    int c    = 0;
    forever begin
      if (tick) seen++;
      if (seen >= n || c >= 4000) break;
      step();
      c++;
    end
    check("wait_ticks", seen, n);
  endtask

  task automatic wait_idle(int k);
    int c = 0;
    repeat (3) step();
    while (busy[k] && c < 8000) begin step(); c++; end
    check($sformatf("u%0d_wait_idle", k), longint'(busy[k]), 0);
  endtask

  task automatic check_quiet(int k, string name);
    check({name, "_play_en"}, longint'(play_en[k]), 0);
    check({name, "_limit"}, longint'(cnt_lim[k]), 0);
    check({name, "_owner"}, longint'(owner[k]), 3);
    check({name, "_busy"}, longint'(busy[k]), 0);
    check({name, "_drop"}, longint'(drop[k]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clr[k] = 1'b0;
      req[k] = 3'b000;
      for (int i = 0; i < 3; i++) begin
        lim[k][i] = '0;
        dur[k][i] = '0;
      end
    end
    repeat (3) step();
    for (int k = 0; k < 3; k++) check_quiet(k, $sformatf("u%0d_reset", k));
    rst = 1'b1;
    step();

    // Single hit tone, then gap, then idle.
    exp_seg(0, 0, 25000, 50, 0);
    exp_idle(0, 20);
    set_req(0, 0, 25000, 50);
    issue(0);
    wait_idle(0);

    // Two strobes in one cycle: beep first, hit after the gap.
    exp_seg(0, 1, 2000, 30, 0);
    exp_seg(0, 0, 1000, 5, 20);
    exp_idle(0, 20);
    set_req(0, 0, 1000, 5);
    set_req(0, 1, 2000, 30);
    issue(0);
    wait_idle(0);

    // Game-over preempts a hit at its 10th tick, with no gap.
    exp_seg(0, 0, 3000, 10, 0);
    set_req(0, 0, 3000, 40);
    issue(0);
    wait_play(0);
    wait_ticks(10);
    step();
    exp_drop(0, 3'b001);
    exp_seg(0, 2, 9000, 100, 0);
    exp_idle(0, 20);
    set_req(0, 2, 9000, 100);
    issue(0);
    wait_idle(0);

    // Two beeps while game-over plays: the later one survives.
    exp_seg(0, 2, 7000, 8, 0);
    exp_seg(0, 1, 6000, 7, 20);
    exp_idle(0, 20);
    set_req(0, 2, 7000, 8);
    issue(0);
    wait_play(0);
    set_req(0, 1, 5000, 6);
    issue(0);
    exp_drop(0, 3'b010);
    set_req(0, 1, 6000, 7);
    issue(0);
    wait_idle(0);

    // Zero-length request is dropped and never plays.
    exp_drop(0, 3'b001);
    set_req(0, 0, 123, 0);
    issue(0);
    repeat (20) step();
    check("zero_dur_busy", longint'(busy[0]), 0);

    // Same owner re-strobes during its own tone: queued, no drop.
    exp_seg(0, 1, 1100, 5, 0);
    exp_seg(0, 1, 1200, 4, 20);
    exp_idle(0, 20);
    set_req(0, 1, 1100, 5);
    issue(0);
    wait_play(0);
    step();
    set_req(0, 1, 1200, 4);
    issue(0);
    wait_idle(0);

    // Grant cycle carries a tick and a new strobe for the slot being consumed.
    exp_seg(0, 0, 1300, 3, 0);
    exp_seg(0, 0, 1400, 3, 20);
    exp_idle(0, 20);
    begin
      int c = 0;
      while (!tick && c < 20) begin step(); c++; end
    end
    repeat (3) step();
    set_req(0, 0, 1300, 3);
    issue(0);
    check("grant_cycle_has_tick", longint'(tick), 1);
    set_req(0, 0, 1400, 3);
    issue(0);
    wait_idle(0);

    // Synchronous flush mid-tone also empties the pending hit slot.
    exp_seg(0, 1, 1500, -1, 0);
    exp_idle(0, 0);
    set_req(0, 1, 1500, 50);
    issue(0);
    wait_play(0);
    wait_ticks(3);
    step();
    set_req(0, 0, 1600, 5);
    issue(0);
    step();
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    check_quiet(0, "clear");
    repeat (60) step();
    check("clear_slots_empty", longint'(busy[0]), 0);

    // Without preemption the game-over waits for the hit plus the gap.
    exp_seg(1, 0, 3000, 40, 0);
    exp_seg(1, 2, 9000, 12, 20);
    exp_idle(1, 20);
    set_req(1, 0, 3000, 40);
    issue(1);
    wait_play(1);
    wait_ticks(10);
    step();
    set_req(1, 2, 9000, 12);
    issue(1);
    wait_idle(1);

    // Without a gap, queued tones run back to back.
    exp_seg(2, 1, 200, 4, 0);
    exp_seg(2, 0, 100, 5, 0);
    exp_idle(2, 0);
    set_req(2, 0, 100, 5);
    set_req(2, 1, 200, 4);
    issue(2);
    wait_idle(2);

    // Asynchronous reset in the middle of a gap with a beep pending.
    exp_seg(0, 0, 1700, 2, 0);
    exp_idle(0, -1);
    set_req(0, 0, 1700, 2);
    issue(0);
    wait_play(0);
    wait_silent(0);
    repeat (2) step();
    set_req(0, 1, 1800, 3);
    issue(0);
    check("gap_busy_before_reset", longint'(busy[0]), 1);
    #1;
    rst = 1'b0;
    #1;
    check_quiet(0, "async_reset");
    step();
    rst = 1'b1;
    repeat (60) step();
    check("reset_slots_empty", longint'(busy[0]), 0);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d_seg_queue_drained", k), seg_q[k].size(), 0);
      check($sformatf("u%0d_drop_queue_drained", k), drop_q[k].size(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
